// File: rtl/mb8_pkg.sv
// Shared definitions for the mb8 dot-product accumulator and the mb8_top benches.
// Holds the state encodings, the default sizes and the term-count decode.
package mb8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int LAT_DEF   = 3;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W     = 9;

  // A len of 0 encodes a full 256-term run.
  function automatic logic [CNT_W-1:0] len_terms(input logic [7:0] len);
    return (len == 8'd0) ? CNT_W'(256) : {1'b0, len};
  endfunction

endpackage

// File: rtl/mb8_vdelay.sv
// Valid-bit delay line that tracks launches through the external multiplier.
// dout rises exactly DEPTH cycles after din is sampled high.
module mb8_vdelay #(
  parameter int DEPTH = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] vld_pipe;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign dout = vld_pipe[DEPTH-1];

endmodule

// File: rtl/mb8_acc.sv
// Dot-product accumulator: issues len operand launches to mb8_top, sums the
// returning products and hands the finished sum downstream with valid/ready.
module mb8_acc
  import mb8_pkg::*;
#(
  parameter int LAT   = LAT_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [7:0]       len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      product,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             drop_err
);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   len_q, issue_cnt, term_cnt;
  logic [ACC_W-1:0]   acc, acc_sum;
  logic               start_acc, accept, prod_tag, term_hit, last_term;

  assign accept    = op_valid & op_ready;
  assign term_hit  = prod_tag & (state == RUN);
  assign last_term = term_hit & ((term_cnt + CNT_W'(1)) == len_q);
  assign acc_sum   = acc + ACC_W'(product);

  mb8_vdelay #(.DEPTH(LAT)) u_vdelay (
    .CLK  (CLK),
    .RST  (RST),
    .din  (accept),
    .dout (prod_tag)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    acc_valid = 1'b0;
    start_acc = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        op_ready = (issue_cnt < len_q);
        if (last_term) state_nxt = HOLD;
      end
      HOLD: begin
        acc_valid = 1'b1;
        // A start alongside the handshake chains straight into the next run.
        if (acc_ready) begin
          if (start) begin
            start_acc = 1'b1;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      len_q     <= '0;
      issue_cnt <= '0;
      term_cnt  <= '0;
      acc       <= '0;
      acc_out   <= '0;
      drop_err  <= 1'b0;
    end else begin
      if (start_acc) begin
        len_q     <= len_terms(len);
        issue_cnt <= '0;
        term_cnt  <= '0;
        acc       <= '0;
      end else begin
        if (accept) issue_cnt <= issue_cnt + CNT_W'(1);
        if (term_hit) begin
          acc      <= acc_sum;
          term_cnt <= term_cnt + CNT_W'(1);
        end
      end
      if (last_term) acc_out <= acc_sum;
      drop_err <= (drop_err & ~start_acc) | (op_valid & ~op_ready);
    end
  end

endmodule

// File: tb/tb_mb8_acc.sv
// Directed bench for mb8_acc with a behavioural stand-in for the mb8_top multiplier.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mb8_acc;
  localparam int LAT = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [15:0] product;
  logic [23:0] acc_out;
  logic        acc_valid;
  logic        acc_ready = 1'b0;
  logic        drop_err;
  logic [7:0]  op_a = 8'd0, op_b = 8'd0;
  logic [LAT-1:0][15:0] pp = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  // Multiplier model: LAT-cycle product pipe fed by every launch attempt.
  always @(posedge CLK) pp <= {pp[LAT-2:0], (op_valid ? 16'(op_a) * 16'(op_b) : 16'd0)};
  assign product = pp[LAT-1];

  mb8_acc dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .op_valid(op_valid),
    .op_ready(op_ready), .product(product), .acc_out(acc_out),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .drop_err(drop_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  // Call on the falling edge right after the last launch was sampled.
  task automatic wait_done(input string tag, input int exp_lat, input logic [23:0] exp_sum);
    int cnt = 1;
    while (!acc_valid && cnt < 20) begin
      cyc();
      cnt++;
    end
    chk({tag, "_lat"}, cnt, exp_lat);
    chk({tag, "_sum"}, acc_out, exp_sum);
  endtask

  task automatic start_run(input logic [7:0] l);
    start = 1'b1; len = l;
    cyc();
    start = 1'b0;
  endtask

  task automatic handshake(input string tag);
    acc_ready = 1'b1;
    cyc();
    acc_ready = 1'b0;
    chk({tag, "_hs_valid"}, acc_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] va [4] = '{8'd3, 8'd7, 8'd255, 8'd0};
    logic [7:0] vb [4] = '{8'd5, 8'd9, 8'd255, 8'd200};

    repeat (3) cyc();
    chk("rst_valid", acc_valid, 0);
    chk("rst_ready", op_ready, 0);
    chk("rst_out", acc_out, 0);
    chk("rst_drop", drop_err, 0);
    RST = 1'b1;
    cyc();

    // Four back-to-back terms.
    start_run(8'd4);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_ready", op_ready, 1);
      op_valid = 1'b1; op_a = va[i]; op_b = vb[i];
      cyc();
    end
    op_valid = 1'b0;
    chk("b2b_ready_done", op_ready, 0);
    wait_done("b2b", 4, 24'd65103);
    handshake("b2b");

    // 256 terms of 255*255 at full rate.
    start_run(8'd0);
    op_valid = 1'b1; op_a = 8'd255; op_b = 8'd255;
    repeat (256) cyc();
    op_valid = 1'b0;
    chk("full_ready_done", op_ready, 0);
    wait_done("full", 4, 24'hFE0100);
    chk("full_drop", drop_err, 0);

    // Stall in HOLD with a stray launch attempt.
    for (int i = 0; i < 5; i++) begin
      op_valid = (i == 2);
      cyc();
      chk("stall_valid", acc_valid, 1);
      chk("stall_out", acc_out, 24'hFE0100);
    end
    op_valid = 1'b0;
    chk("stall_drop", drop_err, 1);

    // Handshake and start together.
    acc_ready = 1'b1; start = 1'b1; len = 8'd1;
    cyc();
    acc_ready = 1'b0; start = 1'b0;
    chk("chain_run", op_ready, 1);
    chk("chain_valid", acc_valid, 0);
    chk("chain_drop_clr", drop_err, 0);
    op_valid = 1'b1; op_a = 8'd2; op_b = 8'd3;
    cyc();
    op_valid = 1'b0;
    wait_done("chain", 4, 24'd6);
    handshake("chain");

    // Launch in IDLE is dropped and flagged.
    op_valid = 1'b1; op_a = 8'd9; op_b = 8'd9;
    cyc();
    op_valid = 1'b0;
    chk("idle_drop", drop_err, 1);

    // Reset mid-run with one launch still in flight.
    start_run(8'd4);
    chk("mid_drop_clr", drop_err, 0);
    op_valid = 1'b1; op_a = 8'd5; op_b = 8'd5;
    cyc();
    op_a = 8'd6; op_b = 8'd6;
    cyc();
    op_valid = 1'b0;
    repeat (4) cyc();
    op_valid = 1'b1; op_a = 8'd7; op_b = 8'd7;
    cyc();
    op_valid = 1'b0;
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_ready", op_ready, 0);
    chk("mid_rst_valid", acc_valid, 0);
    chk("mid_rst_out", acc_out, 0);
    chk("mid_rst_drop", drop_err, 0);
    cyc();
    RST = 1'b1;
    start_run(8'd1);
    op_valid = 1'b1; op_a = 8'd4; op_b = 8'd4;
    cyc();
    op_valid = 1'b0;
    wait_done("post_rst", 4, 24'd16);
    handshake("post_rst");

    // One launch every third cycle.
    start_run(8'd3);
    for (int i = 0; i <= 6; i++) begin
      op_valid = (i % 3 == 0); op_a = 8'd10; op_b = 8'd10;
      cyc();
    end
    op_valid = 1'b0;
    chk("gap_ready_done", op_ready, 0);
    wait_done("gap", 4, 24'd300);
    chk("gap_drop", drop_err, 0);
    handshake("gap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
